// File: rtl/div_seq_ctrl.sv
// ---------------------------------------------------------------------------
// div_seq_ctrl
//   Multi-cycle control wrapper around an external combinational array
//   divider (DIV32). A request is converted to operand magnitudes, which are
//   driven to the divider and held stable for SETTLE_CYCLES cycles so the
//   divider can be constrained as a multicycle path. The divider outputs are
//   then sign-corrected and loaded into the LO (quotient) and HI (remainder)
//   registers.
//
//   Optional feature macro: DIV_EARLY_OUT_EN
//     When defined, a request with a non-zero divisor whose dividend
//     magnitude is below the divisor magnitude skips the settle wait and
//     completes with LO = 0, HI = dividend (latency 2).
//
// Parameters
//   WIDTH          operand/result width (must match the divider)
//   SETTLE_CYCLES  cycles the divider inputs are held before capture (>= 1)
//
// Ports
//   iClk      clock, rising edge
//   inRst     synchronous reset, active low
//   iStart    request strobe, sampled only while idle
//   iSigned   1 = two's-complement divide, 0 = unsigned
//   iA, iB    dividend, divisor
//   oBusy     high whenever an operation is in flight
//   oDone     one-cycle pulse, oLO/oHI/oDivZero valid
//   oLO, oHI  quotient / remainder registers
//   oDivZero  last operation had a zero divisor
//   oDivQ     dividend magnitude to the divider
//   oDivD     divisor magnitude to the divider
//   iDivQ     quotient magnitude from the divider
//   iDivR     remainder magnitude from the divider
// ---------------------------------------------------------------------------
module div_seq_ctrl #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             iClk,
  input  logic             inRst,
  input  logic             iStart,
  input  logic             iSigned,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oLO,
  output logic [WIDTH-1:0] oHI,
  output logic             oDivZero,
  output logic [WIDTH-1:0] oDivQ,
  output logic [WIDTH-1:0] oDivD,
  input  logic [WIDTH-1:0] iDivQ,
  input  logic [WIDTH-1:0] iDivR
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_FIX,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] divq_q, divq_d;
  logic [WIDTH-1:0] divd_q, divd_d;
`ifdef DIV_EARLY_OUT_EN
  logic             early_q, early_d;
`endif

  // Operand signs and magnitudes of the incoming request. Negation wraps at
  // WIDTH bits, so the most negative value maps onto its own bit pattern,
  // which is the correct unsigned magnitude.
  logic             sa_in, sb_in;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign sa_in = iSigned & iA[WIDTH-1];
  assign sb_in = iSigned & iB[WIDTH-1];
  assign mag_a = sa_in ? -iA : iA;
  assign mag_b = sb_in ? -iB : iB;

  always_comb begin
    // NOTE: every signal assigned below gets a default first so no path
    // through the case leaves it unassigned, which would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    zero_d  = zero_q;
    a_d     = a_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    dz_d    = dz_q;
    divq_d  = divq_q;
    divd_d  = divd_q;
`ifdef DIV_EARLY_OUT_EN
    early_d = early_q;
`endif
    oBusy   = (state_q != S_IDLE);
    oDone   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          sa_d   = sa_in;
          sb_d   = sb_in;
          a_d    = iA;
          divq_d = mag_a;
          divd_d = mag_b;
          zero_d = (iB == '0);
          cnt_d  = CNT_LOAD;
`ifdef DIV_EARLY_OUT_EN
          early_d = (iB != '0) && (mag_a < mag_b);
          if ((iB == '0) || (mag_a < mag_b)) begin
            state_d = S_FIX;
          end else begin
            state_d = S_WAIT;
          end
`else
          if (iB == '0) begin
            state_d = S_FIX;
          end else begin
            state_d = S_WAIT;
          end
`endif
        end
      end

      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_FIX: begin
        state_d = S_DONE;
        if (zero_q) begin
          // Divide-by-zero: divider outputs are meaningless and ignored.
          lo_d = '1;
          hi_d = a_q;
          dz_d = 1'b1;
`ifdef DIV_EARLY_OUT_EN
        end else if (early_q) begin
          lo_d = '0;
          hi_d = a_q;
          dz_d = 1'b0;
`endif
        end else begin
          // Quotient is negative when operand signs differ; remainder follows
          // the dividend so that results truncate toward zero.
          lo_d = (sa_q ^ sb_q) ? -iDivQ : iDivQ;
          hi_d = sa_q ? -iDivR : iDivR;
          dz_d = 1'b0;
        end
      end

      S_DONE: begin
        oDone   = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so every
  // register samples the pre-edge values; reset is synchronous, checked
  // inside the clocked block.
  always_ff @(posedge iClk) begin
    if (!inRst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      zero_q  <= 1'b0;
      a_q     <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      dz_q    <= 1'b0;
      divq_q  <= '0;
      divd_q  <= '0;
`ifdef DIV_EARLY_OUT_EN
      early_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      zero_q  <= zero_d;
      a_q     <= a_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      dz_q    <= dz_d;
      divq_q  <= divq_d;
      divd_q  <= divd_d;
`ifdef DIV_EARLY_OUT_EN
      early_q <= early_d;
`endif
    end
  end

  assign oLO      = lo_q;
  assign oHI      = hi_q;
  assign oDivZero = dz_q;
  assign oDivQ    = divq_q;
  assign oDivD    = divd_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_div_seq_ctrl
//   Self-checking bench for div_seq_ctrl. A combinational stand-in for the
//   DIV32 array divider is attached to the divider ports. A reference model
//   derives results from plain / and % arithmetic and operation timing from
//   the documented latencies; one compare process checks every DUT output
//   against it each cycle. Directed cases pin the model with literal values.
// ---------------------------------------------------------------------------
module tb_div_seq_ctrl;

  localparam int W      = 32;
  localparam int SETTLE = 4;

  logic         iClk = 1'b0;
  logic         inRst;
  logic         iStart;
  logic         iSigned;
  logic [W-1:0] iA, iB;
  logic         oBusy, oDone, oDivZero;
  logic [W-1:0] oLO, oHI, oDivQ, oDivD;
  logic [W-1:0] div_q, div_r;

  int checks   = 0;
  int failures = 0;

  always #5 iClk = ~iClk;

  // Stand-in for the combinational DIV32 (unsigned magnitudes).
  assign div_q = (oDivD == '0) ? '1    : oDivQ / oDivD;
  assign div_r = (oDivD == '0) ? oDivQ : oDivQ % oDivD;

  div_seq_ctrl #(.WIDTH(W), .SETTLE_CYCLES(SETTLE)) dut (
    .iClk    (iClk),
    .inRst   (inRst),
    .iStart  (iStart),
    .iSigned (iSigned),
    .iA      (iA),
    .iB      (iB),
    .oBusy   (oBusy),
    .oDone   (oDone),
    .oLO     (oLO),
    .oHI     (oHI),
    .oDivZero(oDivZero),
    .oDivQ   (oDivQ),
    .oDivD   (oDivD),
    .iDivQ   (div_q),
    .iDivR   (div_r)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] mag(input logic [W-1:0] v, input logic s);
    return (s && v[W-1]) ? -v : v;
  endfunction

  function automatic void model_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic s, output logic [W-1:0] lo,
                                       output logic [W-1:0] hi, output logic dz);
    longint sa, sb;
    if (b == '0) begin
      lo = '1;
      hi = a;
      dz = 1'b1;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lo = W'(sa / sb);
      hi = W'(sa % sb);
      dz = 1'b0;
    end else begin
      lo = a / b;
      hi = a % b;
      dz = 1'b0;
    end
  endfunction

  function automatic int model_lat(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    if (b == '0) return 2;
`ifdef DIV_EARLY_OUT_EN
    if (mag(a, s) < mag(b, s)) return 2;
`endif
    return SETTLE + 2;
  endfunction

  // Model state: k counts edges since the accepting edge; the result becomes
  // visible (with oDone) after edge lat-1 and the unit is idle after edge lat.
  bit           m_busy = 1'b0;
  int           m_k    = 0;
  int           m_lat  = 0;
  logic [W-1:0] m_lo = '0, m_hi = '0, m_divq = '0, m_divd = '0;
  logic         m_dz = 1'b0;
  logic [W-1:0] p_lo, p_hi;
  logic         p_dz;

  always begin
    @(posedge iClk);
    #2;
    if (!inRst) begin
      m_busy = 1'b0;
      m_k    = 0;
      m_lo   = '0;
      m_hi   = '0;
      m_dz   = 1'b0;
      m_divq = '0;
      m_divd = '0;
    end else if (m_busy) begin
      m_k++;
      if (m_k == m_lat) m_busy = 1'b0;
    end else if (iStart) begin
      m_busy = 1'b1;
      m_k    = 0;
      model_result(iA, iB, iSigned, p_lo, p_hi, p_dz);
      m_lat  = model_lat(iA, iB, iSigned);
      m_divq = mag(iA, iSigned);
      m_divd = mag(iB, iSigned);
    end
    if (m_busy && m_k == m_lat - 1) begin
      m_lo = p_lo;
      m_hi = p_hi;
      m_dz = p_dz;
    end
    check("busy", 64'(oBusy), 64'(m_busy));
    check("done", 64'(oDone), 64'(m_busy && m_k == m_lat - 1));
    check("lo", 64'(oLO), 64'(m_lo));
    check("hi", 64'(oHI), 64'(m_hi));
    check("divzero", 64'(oDivZero), 64'(m_dz));
    check("divq", 64'(oDivQ), 64'(m_divq));
    check("divd", 64'(oDivD), 64'(m_divd));
  end

  // ---------------- stimulus ----------------
  // Issues one request and returns the latency, counting the accepting edge
  // as cycle 1 (0 if oDone never arrives). With noise set, iStart and the
  // operand inputs are scrambled while the unit is busy.
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                    input bit noise, output int lat);
    @(negedge iClk);
    while (oBusy) @(negedge iClk);
    iA      = a;
    iB      = b;
    iSigned = s;
    iStart  = 1'b1;
    lat     = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge iClk);
      @(negedge iClk);
      if (oDone) begin
        lat    = n;
        iStart = 1'b0;
        break;
      end
      iStart = noise ? ($urandom_range(0, 2) == 0) : 1'b0;
      if (noise) begin
        iA      = $urandom;
        iB      = $urandom;
        iSigned = 1'($urandom_range(0, 1));
      end
    end
    iStart = 1'b0;
  endtask

  int           lat;
  logic [W-1:0] ra, rb;
  logic         rs;

  initial begin
    inRst   = 1'b0;
    iStart  = 1'b0;
    iSigned = 1'b0;
    iA      = '0;
    iB      = '0;
    repeat (3) @(negedge iClk);
    inRst = 1'b1;
    check("rst_lo", 64'(oLO), 64'h0);
    check("rst_busy", 64'(oBusy), 64'h0);

    op(32'd447, 32'd12, 1'b0, 1'b0, lat);
    check("t1_lat", 64'(lat), 64'd6);
    check("t1_lo", 64'(oLO), 64'd37);
    check("t1_hi", 64'(oHI), 64'd3);
    check("t1_dz", 64'(oDivZero), 64'd0);

    op(-32'sd8, 32'd3, 1'b1, 1'b0, lat);
    check("t2a_lo", 64'(oLO), 64'hFFFF_FFFE);
    check("t2a_hi", 64'(oHI), 64'hFFFF_FFFE);
    op(32'd44, -32'sd11, 1'b1, 1'b0, lat);
    check("t2b_lo", 64'(oLO), 64'hFFFF_FFFC);
    check("t2b_hi", 64'(oHI), 64'h0);

    op(32'd1, 32'd0, 1'b0, 1'b0, lat);
    check("t3a_lat", 64'(lat), 64'd2);
    check("t3a_lo", 64'(oLO), 64'hFFFF_FFFF);
    check("t3a_hi", 64'(oHI), 64'd1);
    check("t3a_dz", 64'(oDivZero), 64'd1);
    op(32'd30, 32'd2, 1'b0, 1'b0, lat);
    check("t3b_dz", 64'(oDivZero), 64'd0);
    check("t3b_lo", 64'(oLO), 64'd15);

    op(32'h8000_0000, 32'd2, 1'b0, 1'b0, lat);
    check("t4a_lo", 64'(oLO), 64'h4000_0000);
    check("t4a_hi", 64'(oHI), 64'h0);
    op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, lat);
    check("t4b_lo", 64'(oLO), 64'h8000_0000);
    check("t4b_hi", 64'(oHI), 64'h0);

    // Reset in the middle of an operation, with a stray iStart while busy.
    @(negedge iClk);
    while (oBusy) @(negedge iClk);
    iA = 32'd3000; iB = 32'd200; iSigned = 1'b0; iStart = 1'b1;
    @(negedge iClk) iStart = 1'b0;
    @(negedge iClk) iStart = 1'b1;
    @(negedge iClk) begin iStart = 1'b0; inRst = 1'b0; end
    @(negedge iClk) inRst = 1'b1;
    check("t5_busy", 64'(oBusy), 64'h0);
    check("t5_done", 64'(oDone), 64'h0);
    check("t5_lo", 64'(oLO), 64'h0);
    check("t5_hi", 64'(oHI), 64'h0);
    check("t5_divq", 64'(oDivQ), 64'h0);
    op(32'd300, 32'd20, 1'b0, 1'b0, lat);
    check("t5b_lo", 64'(oLO), 64'd15);
    check("t5b_hi", 64'(oHI), 64'd0);

    op(32'd5, 32'd7, 1'b0, 1'b0, lat);
`ifdef DIV_EARLY_OUT_EN
    check("t6_lat", 64'(lat), 64'd2);
`else
    check("t6_lat", 64'(lat), 64'd6);
`endif
    check("t6_lo", 64'(oLO), 64'd0);
    check("t6_hi", 64'(oHI), 64'd5);

    // Randomised operations with busy-time noise on the inputs.
    for (int i = 0; i < 200; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 20));
        2:       begin ra = W'($urandom_range(0, 50)); rb = $urandom; end
        3:       rb = -W'($urandom_range(1, 9));
        default: rb = $urandom;
      endcase
      op(ra, rb, rs, 1'b1, lat);
      check("rand_lat", 64'(lat), 64'(model_lat(ra, rb, rs)));
    end

    repeat (3) @(negedge iClk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
